// File: rtl/matched_filter_mac_if.sv
// Sample-in / score-out stream bundle for matched_filter_mac.
// master drives samples, slave produces scores.
interface matched_filter_mac_if #(
  parameter int SW = 8,
  parameter int MW = 16
);
  logic                 axiiv;
  logic signed [SW-1:0] axiid;
  logic                 axiir;
  logic                 axiov;
  logic signed [MW-1:0] axiod;
  logic                 match;

  modport master (
    output axiiv, axiid,
    input  axiir, axiov, axiod, match
  );

  modport slave (
    input  axiiv, axiid,
    output axiir, axiov, axiod, match
  );
endinterface

// File: rtl/matched_filter_mac.sv
// Sliding-window correlator: one shared multiplier walks the template
// once per accepted sample, then saturates and thresholds the score.
module matched_filter_mac #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int COEF_WIDTH        = 8,
  parameter int NUM_TAPS          = 32,
  parameter int MATCH_SCORE_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  matched_filter_mac_if.slave                 bus,
  input  logic                                coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0]         coef_addr,
  input  logic signed [COEF_WIDTH-1:0]        coef_data,
  input  logic signed [MATCH_SCORE_WIDTH-1:0] threshold,
  input  logic                                clear
);
  localparam int SW = SAMPLE_DATA_WIDTH;
  localparam int CW = COEF_WIDTH;
  localparam int MW = MATCH_SCORE_WIDTH;
  localparam int IW = $clog2(NUM_TAPS);
  localparam int FW = $clog2(NUM_TAPS + 1);
  localparam int PW = SW + CW;
  localparam int AW = PW + IW;

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-MW+1){1'b0}}, {(MW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-MW+1){1'b1}}, {(MW-1){1'b0}}};
  localparam logic signed [MW-1:0] MMAX = {1'b0, {(MW-1){1'b1}}};
  localparam logic signed [MW-1:0] MMIN = {1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic signed [SW-1:0] win_q  [NUM_TAPS];
  logic signed [SW-1:0] win_d  [NUM_TAPS];
  logic signed [CW-1:0] coef_q [NUM_TAPS];
  logic signed [CW-1:0] coef_d [NUM_TAPS];
  logic signed [AW-1:0] acc_q, acc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 rdy_q, rdy_d;
  logic                 axiov_q, axiov_d;
  logic signed [MW-1:0] axiod_q, axiod_d;
  logic                 match_q, match_d;

  logic signed [SW-1:0] w_sel;
  logic signed [CW-1:0] c_sel;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic signed [MW-1:0] sat_v;

  always_comb begin
    w_sel   = win_q[idx_q];
    c_sel   = coef_q[idx_q];
    prod    = $signed({{CW{w_sel[SW-1]}}, w_sel} *
                      {{SW{c_sel[CW-1]}}, c_sel});
    acc_sum = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
    if (acc_sum > SMAX)      sat_v = MMAX;
    else if (acc_sum < SMIN) sat_v = MMIN;
    else                     sat_v = acc_sum[MW-1:0];
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    coef_d  = coef_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    axiov_d = 1'b0;
    axiod_d = axiod_q;
    match_d = match_q;
    unique case (state_q)
      IDLE: begin
        if (coef_we) coef_d[coef_addr] = coef_data;
        if (clear) begin
          for (int k = 0; k < NUM_TAPS; k++) win_d[k] = '0;
          fill_d = '0;
        end else if (bus.axiiv && rdy_q) begin
          for (int k = NUM_TAPS-1; k > 0; k--) win_d[k] = win_q[k-1];
          win_d[0] = bus.axiid;
          if (fill_q != FW'(NUM_TAPS)) fill_d = fill_q + 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_TAPS-1)) begin
          state_d = OUT;
          // Outputs register on the last product so the pulse lands in OUT.
          if (fill_q == FW'(NUM_TAPS)) begin
            axiov_d = 1'b1;
            axiod_d = sat_v;
            match_d = sat_v >= threshold;
          end
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_TAPS; k++) begin
        win_q[k]  <= '0;
        coef_q[k] <= '0;
      end
      acc_q   <= '0;
      idx_q   <= '0;
      fill_q  <= '0;
      rdy_q   <= 1'b0;
      axiov_q <= 1'b0;
      axiod_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      coef_q  <= coef_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      fill_q  <= fill_d;
      rdy_q   <= rdy_d;
      axiov_q <= axiov_d;
      axiod_q <= axiod_d;
      match_q <= match_d;
    end
  end

  assign bus.axiir = rdy_q;
  assign bus.axiov = axiov_q;
  assign bus.axiod = axiod_q;
  assign bus.match = match_q;
endmodule

// File: tb/tb_matched_filter_mac.sv
// Scoreboard bench for matched_filter_mac with 32 taps.
// Directed vectors push expected scores; a monitor checks each pulse.
module tb_matched_filter_mac;
  logic              clk;
  logic              rst_n;
  logic              coef_we;
  logic [4:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic signed [15:0] threshold;
  logic              clear;

  matched_filter_mac_if #(.SW(8), .MW(16)) bus ();

  matched_filter_mac dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .threshold (threshold),
    .clear     (clear)
  );

  typedef struct {
    int sc;
    int m;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (bus.axiov) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_axiov", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("axiod", int'($signed(bus.axiod)), e.sc);
        chk("match", int'(bus.match), e.m);
      end
    end
  end

  task automatic set_coef(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = 5'(a);
    coef_data = 8'(v);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int a = 0; a < 32; a++) set_coef(a, v);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic send(input int x, input bit exp_p, input int sc,
                      input int m, input bit hold, input bit mac_we,
                      input bit hs_we);
    int k;
    int low;
    int ov;
    k = 0;
    while (!bus.axiir && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!bus.axiir) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    if (exp_p) exp_q.push_back('{sc: sc, m: m});
    bus.axiiv = 1'b1;
    bus.axiid = 8'(x);
    if (hs_we) begin
      coef_we   = 1'b1;
      coef_addr = 5'd0;
      coef_data = 8'sd5;
    end
    @(posedge clk);
    #1;
    if (!hold) bus.axiiv = 1'b0;
    coef_we = 1'b0;
    low = 0;
    ov  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mac_we) begin
        coef_we   = (i <= 30);
        coef_addr = 5'd0;
        coef_data = 8'sd100;
      end
      if (bus.axiov) ov = i;
      if (bus.axiir) begin
        bus.axiiv = 1'b0;
        coef_we   = 1'b0;
        break;
      end
      low++;
    end
    chk("axiir_low_cycles", low, 33);
    if (exp_p) chk("axiov_latency", ov, 33);
  endtask

  task automatic prime(input int v);
    for (int i = 0; i < 31; i++) send(v, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.axiiv = 1'b0;
    bus.axiid = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    threshold = '0;
    clear     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_axiir", int'(bus.axiir), 0);
    chk("rst_axiov", int'(bus.axiov), 0);
    chk("rst_axiod", int'($signed(bus.axiod)), 0);
    chk("rst_match", int'(bus.match), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("axiir_after_rst", int'(bus.axiir), 1);

    // ramp with unit template
    set_all(1);
    threshold = 16'sd528;
    for (int i = 1; i <= 31; i++) send(i, 0, 0, 0, 0, 0, 0);
    send(32, 1, 528, 1, 0, 0, 0);
    threshold = 16'sd560;
    send(33, 1, 560, 1, 0, 0, 0);
    threshold = 16'sd593;
    send(34, 1, 592, 0, 0, 0, 0);

    // single-tap template, axiiv held through MAC
    do_clear();
    set_all(0);
    set_coef(0, 3);
    threshold = 16'sd0;
    for (int i = 1; i <= 31; i++) send(i, 0, 0, 0, 0, 0, 0);
    send(32, 1, 96, 1, 0, 0, 0);
    send(33, 1, 99, 1, 1, 0, 0);
    send(-5, 1, -15, 0, 1, 0, 0);

    // saturation both ways
    do_clear();
    set_all(-128);
    threshold = -16'sd32768;
    prime(-128);
    send(-128, 1, 32767, 1, 0, 0, 0);
    do_clear();
    prime(127);
    send(127, 1, -32768, 1, 0, 0, 0);

    // coefficient write gating
    do_clear();
    set_all(1);
    threshold = 16'sd0;
    prime(1);
    send(1, 1, 32, 1, 0, 0, 0);
    send(1, 1, 32, 1, 0, 1, 0);
    send(1, 1, 36, 1, 0, 0, 1);

    // reset in the middle of MAC
    bus.axiiv = 1'b1;
    bus.axiid = 8'sd1;
    @(posedge clk);
    #1;
    bus.axiiv = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midmac_axiov", int'(bus.axiov), 0);
    chk("midmac_axiod", int'($signed(bus.axiod)), 0);
    chk("midmac_match", int'(bus.match), 0);
    chk("midmac_axiir", int'(bus.axiir), 0);
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_all(1);
    prime(1);
    send(1, 1, 32, 1, 0, 0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
